// File: rtl/model_matrix_sequencer.sv
// model_matrix_sequencer
//   Builds the 4x4 Q8.8 model matrix M = T * Ry(angle) * S(scale) for one
//   object per job. A shared external sine unit is called twice per job,
//   once for sin(angle) and once for sin(angle + pi/2) = cos(angle). The
//   finished matrix is held until the vertex-transform stage consumes it.
//
// Ports
//   Clk, Reset          clock, asynchronous active-high reset
//   start / ready       job request handshake (ready only while idle)
//   angle, scale        Q8.8 signed rotation angle (radians) and uniform scale
//   x/y/z_translate     Q8.8 signed translation
//   sin_req / sin_arg   request and argument to the shared sine unit
//   sin_ack / sin_data  sine unit acceptance and Q8.8 result (same cycle)
//   matrix_out          16 packed Q8.8 elements, element i = row i/4, col i%4
//   matrix_valid        matrix_out and overflow are valid
//   matrix_ready        downstream consume strobe
//   overflow            sticky saturation flag for the current job
module model_matrix_sequencer #(
    parameter logic signed [15:0] HALF_PI = 16'sh0192,
    parameter logic signed [15:0] ONE     = 16'sh0100
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    output logic              ready,
    input  logic [15:0]       angle,
    input  logic [15:0]       scale,
    input  logic [15:0]       x_translate,
    input  logic [15:0]       y_translate,
    input  logic [15:0]       z_translate,
    output logic              sin_req,
    output logic [15:0]       sin_arg,
    input  logic              sin_ack,
    input  logic [15:0]       sin_data,
    output logic [15:0][15:0] matrix_out,
    output logic              matrix_valid,
    input  logic              matrix_ready,
    output logic              overflow
);

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {IDLE, SIN, COS, MUL, NEG, DONE} state_t;

    state_t                     state;
    logic signed [DATA_W-1:0]   angle_r, scale_r, x_r, y_r, z_r;
    logic signed [DATA_W-1:0]   sin_r, cos_r, smc, sms;
    logic        [DATA_W:0]     mul_c, mul_s, neg_s;
    logic [15:0][DATA_W-1:0]    mat_n;

    // Q8.8 multiply: keep product[23:8] (floor), saturate when the discarded
    // upper bits are not a sign extension. Bit DATA_W flags saturation.
    function automatic logic [DATA_W:0] mul_sat(input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] p;
        p = a * b;
        if (p[31:23] == 9'h000 || p[31:23] == 9'h1FF)
            return {1'b0, p[23:8]};
        else if (p[31])
            return {1'b1, 16'h8000};
        else
            return {1'b1, 16'h7FFF};
    endfunction

    // Negate with the single unrepresentable case (-(-32768)) saturated.
    function automatic logic [DATA_W:0] neg_sat(input logic signed [DATA_W-1:0] a);
        if (a == 16'sh8000)
            return {1'b1, 16'h7FFF};
        else
            return {1'b0, -a};
    endfunction

    assign ready = (state == IDLE);
    assign mul_c = mul_sat(scale_r, cos_r);
    assign mul_s = mul_sat(scale_r, sin_r);
    assign neg_s = neg_sat(sms);

    always_comb begin
        mat_n     = '0;
        mat_n[0]  = smc;
        mat_n[2]  = sms;
        mat_n[3]  = x_r;
        mat_n[5]  = scale_r;
        mat_n[7]  = y_r;
        mat_n[8]  = neg_s[DATA_W-1:0];
        mat_n[10] = smc;
        mat_n[11] = z_r;
        mat_n[15] = ONE;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            sin_req      <= 1'b0;
            sin_arg      <= '0;
            matrix_out   <= '0;
            matrix_valid <= 1'b0;
            overflow     <= 1'b0;
            angle_r      <= '0;
            scale_r      <= '0;
            x_r          <= '0;
            y_r          <= '0;
            z_r          <= '0;
            sin_r        <= '0;
            cos_r        <= '0;
            smc          <= '0;
            sms          <= '0;
        end else begin
            case (state)
                // Accept: latch the job and launch the sine request at once
                IDLE: begin
                    if (start) begin
                        angle_r  <= angle;
                        scale_r  <= scale;
                        x_r      <= x_translate;
                        y_r      <= y_translate;
                        z_r      <= z_translate;
                        overflow <= 1'b0;
                        sin_req  <= 1'b1;
                        sin_arg  <= angle;
                        state    <= SIN;
                    end
                end
                // sin(angle); request stays up, argument switches to the cosine one
                SIN: begin
                    if (sin_ack) begin
                        sin_r   <= sin_data;
                        sin_arg <= angle_r + HALF_PI;
                        state   <= COS;
                    end
                end
                // cos(angle) = sin(angle + pi/2)
                COS: begin
                    if (sin_ack) begin
                        cos_r   <= sin_data;
                        sin_req <= 1'b0;
                        state   <= MUL;
                    end
                end
                // Scaled rotation terms
                MUL: begin
                    smc      <= mul_c[DATA_W-1:0];
                    sms      <= mul_s[DATA_W-1:0];
                    overflow <= overflow | mul_c[DATA_W] | mul_s[DATA_W];
                    state    <= NEG;
                end
                // Negated term and matrix assembly
                NEG: begin
                    matrix_out   <= mat_n;
                    overflow     <= overflow | neg_s[DATA_W];
                    matrix_valid <= 1'b1;
                    state        <= DONE;
                end
                // Hold until consumed; matrix_out keeps its value afterwards
                DONE: begin
                    if (matrix_ready) begin
                        matrix_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
